pipeline_exec_ctrl: RTL and testbench

Execution controller for the 5-stage pipeline. It drives the shared `pipeline_mode` / `run_clockcycle` pair into every inter-stage latch (IF/ID, ID/EX, EX/MEM, MEM/WB). It runs commands from the debug unit: continuous run, single step, halt and clear. After every stop it requests a latch/register dump from the debug unit through a req/done handshake. It freezes the pipeline permanently when the EOF flag reaches the MEM/WB latch output.

---
 rtl/pipeline_exec_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_exec_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_exec_ctrl.sv
// pipeline_exec_ctrl
//   Execution controller for the 5-stage pipeline. Drives the shared
//   pipeline_mode / run_clockcycle pair into every inter-stage latch, runs
//   debug-unit commands (run, step, halt, clear), requests a latch dump after
//   every stop and freezes for good once EOF reaches the MEM/WB latch output.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_cmd_valid/i_cmd   command byte: 'C' run, 'S' step, 'H' halt, 'R' clear
//   o_cmd_ready         command accepted on i_cmd_valid && o_cmd_ready
//   i_EOF_flag          EOF flag seen at the MEM/WB latch output
//   o_pipeline_mode     00 frozen/idle, 01 continuous, 11 stepwise
//   o_run_clockcycle    single-cycle advance strobe (with mode 11)
//   o_dump_req          dump request to the debug unit
//   i_dump_done         debug unit finished the dump
//   o_cycle_count       pipeline advances since last clear (wraps)
//   o_state             IDLE=0 RUN=1 STEP=2 DUMP=3 DONE=4
//   o_halted            program finished
module pipeline_exec_ctrl #(
    parameter int NB_CYCLES = 32,
    parameter int NB_CMD    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [NB_CMD-1:0]    i_cmd,
    output logic                 o_cmd_ready,
    input  logic                 i_EOF_flag,
    output logic [1:0]           o_pipeline_mode,
    output logic                 o_run_clockcycle,
    output logic                 o_dump_req,
    input  logic                 i_dump_done,
    output logic [NB_CYCLES-1:0] o_cycle_count,
    output logic [2:0]           o_state,
    output logic                 o_halted
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_STEP = 3'd2,
        S_DUMP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [NB_CMD-1:0] CMD_RUN  = NB_CMD'(8'h43);
    localparam logic [NB_CMD-1:0] CMD_STEP = NB_CMD'(8'h53);
    localparam logic [NB_CMD-1:0] CMD_HALT = NB_CMD'(8'h48);
    localparam logic [NB_CMD-1:0] CMD_CLR  = NB_CMD'(8'h52);

    state_t               state;
    logic                 eof_seen;
    logic [NB_CYCLES-1:0] cycle_count;
    logic                 cmd_acc;
    logic                 advance;
    logic                 clear;

    assign cmd_acc = i_cmd_valid && o_cmd_ready;

    // An edge advances the latches when mode is 01 or the step strobe is up;
    // this is exactly RUN without EOF, or STEP.
    assign advance = ((state == S_RUN) && !i_EOF_flag) || (state == S_STEP);

    // 'R' is only acted on from IDLE and DONE
    assign clear = cmd_acc && (i_cmd == CMD_CLR) &&
                   ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_IDLE;
            eof_seen    <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (clear)
                cycle_count <= '0;
            else if (advance)
                cycle_count <= cycle_count + NB_CYCLES'(1);

            if (clear)
                eof_seen <= 1'b0;
            else if (i_EOF_flag && ((state == S_RUN) || (state == S_STEP) ||
                                    (state == S_DUMP)))
                eof_seen <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cmd_acc && (i_cmd == CMD_RUN))
                        state <= S_RUN;
                    else if (cmd_acc && (i_cmd == CMD_STEP))
                        state <= S_STEP;
                end
                S_RUN: begin
                    if (i_EOF_flag || (cmd_acc && (i_cmd == CMD_HALT)))
                        state <= S_DUMP;
                end
                S_STEP:
                    state <= S_DUMP;
                S_DUMP: begin
                    // EOF may arrive in the very cycle the dump completes
                    if (i_dump_done)
                        state <= (eof_seen || i_EOF_flag) ? S_DONE : S_IDLE;
                end
                S_DONE: begin
                    if (clear)
                        state <= S_IDLE;
                end
                default:
                    state <= S_IDLE;
            endcase
        end
    end

    // Moore decode; RUN mode drops to 11 in the same cycle EOF shows up so
    // the instruction carrying EOF is not pushed further.
    always_comb begin
        o_pipeline_mode  = 2'b00;
        o_run_clockcycle = 1'b0;
        o_dump_req       = 1'b0;
        o_halted         = 1'b0;
        o_cmd_ready      = 1'b0;
        case (state)
            S_IDLE: o_cmd_ready = 1'b1;
            S_RUN: begin
                o_pipeline_mode = i_EOF_flag ? 2'b11 : 2'b01;
                o_cmd_ready     = 1'b1;
            end
            S_STEP: begin
                o_pipeline_mode  = 2'b11;
                o_run_clockcycle = 1'b1;
            end
            S_DUMP: begin
                o_pipeline_mode = 2'b11;
                o_dump_req      = 1'b1;
            end
            S_DONE: begin
                o_pipeline_mode = 2'b11;
                o_halted        = 1'b1;
                o_cmd_ready     = 1'b1;
            end
            default: ;
        endcase
        if (i_reset)
            o_cmd_ready = 1'b0;
    end

    assign o_cycle_count = cycle_count;
    assign o_state       = state;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
module tb_pipeline_exec_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_cmd_valid;
    logic [7:0]  i_cmd;
    logic        o_cmd_ready;
    logic        i_EOF_flag;
    logic [1:0]  o_pipeline_mode;
    logic        o_run_clockcycle;
    logic        o_dump_req;
    logic        i_dump_done;
    logic [31:0] o_cycle_count;
    logic [2:0]  o_state;
    logic        o_halted;

    // narrow-counter copy sharing the same stimulus, used for the wrap check
    logic        w_cmd_ready, w_run, w_req, w_halted;
    logic [1:0]  w_mode;
    logic [3:0]  w_count;
    logic [2:0]  w_state;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    typedef struct {
        logic [31:0] cnt;
        logic [2:0]  nxt;
    } exp_t;
    exp_t exp_q[$];

    always #5 i_clk = ~i_clk;

    pipeline_exec_ctrl #(.NB_CYCLES(32), .NB_CMD(8)) u_dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid),
        .i_cmd(i_cmd), .o_cmd_ready(o_cmd_ready), .i_EOF_flag(i_EOF_flag),
        .o_pipeline_mode(o_pipeline_mode), .o_run_clockcycle(o_run_clockcycle),
        .o_dump_req(o_dump_req), .i_dump_done(i_dump_done),
        .o_cycle_count(o_cycle_count), .o_state(o_state), .o_halted(o_halted)
    );

    pipeline_exec_ctrl #(.NB_CYCLES(4), .NB_CMD(8)) u_dut4 (
        .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid),
        .i_cmd(i_cmd), .o_cmd_ready(w_cmd_ready), .i_EOF_flag(i_EOF_flag),
        .o_pipeline_mode(w_mode), .o_run_clockcycle(w_run),
        .o_dump_req(w_req), .i_dump_done(i_dump_done),
        .o_cycle_count(w_count), .o_state(w_state), .o_halted(w_halted)
    );

    always @(posedge i_clk) if (o_run_clockcycle) strobes <= strobes + 1;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    // Waits for the dump request, pops the expected entry, acks 2 cycles
    // later and checks where the controller lands.
    task automatic do_dump(input string tag);
        exp_t e;
        int   n = 0;
        while (!o_dump_req && n < 20) begin
            tick();
            n++;
        end
        e = exp_q.pop_front();
        checks++;
        if (o_dump_req !== 1'b1) begin
            errors++;
            $display("FAIL %s dump_req timeout got=%b exp=1", tag, o_dump_req);
            return;
        end
        checks++;
        if (o_cycle_count !== e.cnt) begin
            errors++;
            $display("FAIL %s count got=%0d exp=%0d", tag, o_cycle_count, e.cnt);
        end
        checks++;
        if (o_pipeline_mode !== 2'b11 || o_run_clockcycle !== 1'b0 || o_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s dump outputs got mode=%b run=%b rdy=%b exp mode=11 run=0 rdy=0",
                     tag, o_pipeline_mode, o_run_clockcycle, o_cmd_ready);
        end
        repeat (2) tick();
        i_dump_done = 1'b1;
        tick();
        i_dump_done = 1'b0;
        checks++;
        if (o_dump_req !== 1'b0 || o_state !== e.nxt || o_halted !== (e.nxt == 3'd4)) begin
            errors++;
            $display("FAIL %s after ack got req=%b state=%0d halted=%b exp req=0 state=%0d",
                     tag, o_dump_req, o_state, o_halted, e.nxt);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (o_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0", o_cmd_ready);
        end
        checks++;
        if (o_state !== 3'd0 || o_pipeline_mode !== 2'b00 || o_cycle_count !== 32'd0 ||
            o_dump_req !== 1'b0 || o_run_clockcycle !== 1'b0 || o_halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got state=%0d mode=%b cnt=%0d req=%b run=%b halt=%b exp all 0",
                     o_state, o_pipeline_mode, o_cycle_count, o_dump_req, o_run_clockcycle, o_halted);
        end
        i_reset = 1'b0;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b exp=1", o_cmd_ready);
        end
        send(8'h00);
        send(8'h48);
        checks++;
        if (o_state !== 3'd0 || o_pipeline_mode !== 2'b00) begin
            errors++;
            $display("FAIL idle_ignore got state=%0d mode=%b exp state=0 mode=00", o_state, o_pipeline_mode);
        end
    endtask

    task automatic test_step();
        int s0 = strobes;
        for (int i = 0; i < 3; i++) begin
            send(8'h53);
            checks++;
            if (o_state !== 3'd2 || o_run_clockcycle !== 1'b1 || o_pipeline_mode !== 2'b11 ||
                o_cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL step_cycle got state=%0d run=%b mode=%b rdy=%b exp 2/1/11/0",
                         o_state, o_run_clockcycle, o_pipeline_mode, o_cmd_ready);
            end
            exp_q.push_back('{cnt: 32'(i + 1), nxt: 3'd0});
            do_dump("step");
        end
        checks++;
        if (strobes - s0 !== 3 || o_cycle_count !== 32'd3) begin
            errors++;
            $display("FAIL step_total got strobes=%0d cnt=%0d exp strobes=3 cnt=3",
                     strobes - s0, o_cycle_count);
        end
    endtask

    task automatic test_run_halt();
        send(8'h52);
        checks++;
        if (o_cycle_count !== 32'd0 || o_state !== 3'd0) begin
            errors++;
            $display("FAIL clear got cnt=%0d state=%0d exp cnt=0 state=0", o_cycle_count, o_state);
        end
        send(8'h43);
        checks++;
        if (o_state !== 3'd1 || o_pipeline_mode !== 2'b01 || o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL run_entry got state=%0d mode=%b rdy=%b exp 1/01/1",
                     o_state, o_pipeline_mode, o_cmd_ready);
        end
        repeat (9) tick();
        exp_q.push_back('{cnt: 32'd10, nxt: 3'd0});
        send(8'h48);
        do_dump("halt");
        checks++;
        if (o_pipeline_mode !== 2'b00 || o_cycle_count !== 32'd10) begin
            errors++;
            $display("FAIL halt_idle got mode=%b cnt=%0d exp mode=00 cnt=10", o_pipeline_mode, o_cycle_count);
        end
    endtask

    task automatic test_eof();
        send(8'h52);
        send(8'h43);
        repeat (19) tick();
        i_EOF_flag = 1'b1;
        #1;
        checks++;
        if (o_pipeline_mode !== 2'b11) begin
            errors++;
            $display("FAIL eof_freeze mode got=%b exp=11", o_pipeline_mode);
        end
        exp_q.push_back('{cnt: 32'd19, nxt: 3'd4});
        do_dump("eof");
        send(8'h53);
        checks++;
        if (o_state !== 3'd4 || o_cycle_count !== 32'd19 || o_halted !== 1'b1) begin
            errors++;
            $display("FAIL done_ignore got state=%0d cnt=%0d halt=%b exp 4/19/1",
                     o_state, o_cycle_count, o_halted);
        end
        i_EOF_flag = 1'b0;
        send(8'h52);
        checks++;
        if (o_state !== 3'd0 || o_cycle_count !== 32'd0 || o_halted !== 1'b0) begin
            errors++;
            $display("FAIL done_clear got state=%0d cnt=%0d halt=%b exp 0/0/0",
                     o_state, o_cycle_count, o_halted);
        end
    endtask

    task automatic test_wrap();
        send(8'h43);
        repeat (16) tick();
        exp_q.push_back('{cnt: 32'd17, nxt: 3'd0});
        send(8'h48);
        do_dump("wrap");
        checks++;
        if (w_count !== 4'd1) begin
            errors++;
            $display("FAIL wrap_count got=%0d exp=1", w_count);
        end
    endtask

    task automatic test_reset_dump();
        send(8'h53);
        tick();
        checks++;
        if (o_dump_req !== 1'b1 || o_state !== 3'd3) begin
            errors++;
            $display("FAIL rst_dump_pre got req=%b state=%0d exp req=1 state=3", o_dump_req, o_state);
        end
        i_reset = 1'b1;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_dump_ready got=%b exp=0", o_cmd_ready);
        end
        tick();
        checks++;
        if (o_dump_req !== 1'b0 || o_state !== 3'd0 || o_cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL rst_dump got req=%b state=%0d cnt=%0d exp 0/0/0",
                     o_dump_req, o_state, o_cycle_count);
        end
        i_reset     = 1'b0;
        i_dump_done = 1'b1;
        tick();
        i_dump_done = 1'b0;
        checks++;
        if (o_dump_req !== 1'b0 || o_state !== 3'd0 || o_pipeline_mode !== 2'b00 || o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL late_done got req=%b state=%0d mode=%b rdy=%b exp 0/0/00/1",
                     o_dump_req, o_state, o_pipeline_mode, o_cmd_ready);
        end
    endtask

    initial begin
        i_reset     = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd       = 8'h00;
        i_EOF_flag  = 1'b0;
        i_dump_done = 1'b0;
        repeat (2) tick();
        test_reset();
        test_step();
        test_run_halt();
        test_eof();
        test_wrap();
        test_reset_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
